controller_op_stack: RTL and testbench

- Operator stack (LIFO) that produces `op_data` / `op_empty` for the controller.
- The operator registers (`operator_x`, `operator`) load from `op_data`, e.g. in `CS_COMPARE`. This block is the writer/owner side of that interface.
- It accepts push/pop/clear commands from the controller state logic and always presents the current top-of-stack as a registered value.
- It sits beside the data stack in the controller memory group.

---
 rtl/controller_op_stack.sv | 89 ++++++++
 tb/tb_controller_op_stack.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/controller_op_stack.sv
// Operator LIFO feeding op_data/op_empty to the controller.
// Top entry is held in op_data; lower entries live in mem[].
module controller_op_stack #(
    parameter int OP_W  = 4,
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             op_push,
    input  logic             op_pop,
    input  logic             op_clear,
    input  logic [OP_W-1:0]  op_wdata,
    output logic [OP_W-1:0]  op_data,
    output logic             op_empty,
    output logic             op_full,
    output logic [PTR_W:0]   op_count,
    output logic             op_ovf,
    output logic             op_udf
);

    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);

    logic [OP_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] wr_idx;
    logic [PTR_W-1:0] rd_idx;
    logic             is_empty;
    logic             is_full;
    logic             spill;

    assign is_empty = (op_count == '0);
    assign is_full  = (op_count == CNT_FULL);
    assign op_empty = is_empty;
    assign op_full  = is_full;

    // slot just below the current top, and the one a pop promotes
    assign wr_idx = op_count[PTR_W-1:0] - PTR_W'(1);
    assign rd_idx = op_count[PTR_W-1:0] - PTR_W'(2);

    // a plain push onto a non-empty, non-full stack spills the old top
    assign spill = Reset && !op_clear && op_push && !op_pop
                   && !is_full && !is_empty;

    // storage below the top; never reset, only valid below op_count-1
    always_ff @(posedge Clock) begin
        if (spill) begin
            mem[wr_idx] <= op_data;
        end
    end

    // top register, count and sticky error flags
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            op_count <= '0;
            op_data  <= '0;
            op_ovf   <= 1'b0;
            op_udf   <= 1'b0;
        end else if (op_clear) begin
            op_count <= '0;
            op_data  <= '0;
            op_ovf   <= 1'b0;
            op_udf   <= 1'b0;
        end else if (op_push && op_pop) begin
            op_data <= op_wdata;
            if (is_empty) begin
                op_count <= CNT_ONE;
            end
        end else if (op_push) begin
            if (is_full) begin
                op_ovf <= 1'b1;
            end else begin
                op_data  <= op_wdata;
                op_count <= op_count + CNT_ONE;
            end
        end else if (op_pop) begin
            if (is_empty) begin
                op_udf <= 1'b1;
            end else if (op_count == CNT_ONE) begin
                op_data  <= '0;
                op_count <= '0;
            end else begin
                op_data  <= mem[rd_idx];
                op_count <= op_count - CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_controller_op_stack.sv
// Bench for controller_op_stack: queue model, per-cycle compare,
// directed scenarios with literal expectations, then random traffic.
module tb_controller_op_stack;

    logic       Clock;
    logic       Reset;
    logic       op_push;
    logic       op_pop;
    logic       op_clear;
    logic [3:0] op_wdata;
    logic [3:0] op_data;
    logic       op_empty;
    logic       op_full;
    logic [4:0] op_count;
    logic       op_ovf;
    logic       op_udf;

    int errs   = 0;
    int checks = 0;
    bit chk_en = 0;

    int q[$];
    bit m_ovf;
    bit m_udf;

    controller_op_stack #(.OP_W(4), .DEPTH(16), .PTR_W(4)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .op_push  (op_push),
        .op_pop   (op_pop),
        .op_clear (op_clear),
        .op_wdata (op_wdata),
        .op_data  (op_data),
        .op_empty (op_empty),
        .op_full  (op_full),
        .op_count (op_count),
        .op_ovf   (op_ovf),
        .op_udf   (op_udf)
    );

    initial Clock = 0;
    always #5 Clock = ~Clock;

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic int m_top();
        if (q.size() == 0) return 0;
        return q[q.size()-1];
    endfunction

    // behavioural update for one sampled edge
    task automatic model(bit r, bit pu, bit po, bit cl, int w);
        if (!r) begin
            q.delete();
            m_ovf = 0;
            m_udf = 0;
        end else if (cl) begin
            q.delete();
            m_ovf = 0;
            m_udf = 0;
        end else if (pu && po) begin
            if (q.size() == 0) q.push_back(w);
            else q[q.size()-1] = w;
        end else if (pu) begin
            if (q.size() == 16) m_ovf = 1;
            else q.push_back(w);
        end else if (po) begin
            if (q.size() == 0) m_udf = 1;
            else void'(q.pop_back());
        end
    endtask

    // compare every cycle, away from the active edge
    always @(negedge Clock) begin
        if (chk_en) begin
            chk("data",  int'(op_data),  m_top());
            chk("count", int'(op_count), q.size());
            chk("empty", int'(op_empty), int'(q.size() == 0));
            chk("full",  int'(op_full),  int'(q.size() == 16));
            chk("ovf",   int'(op_ovf),   int'(m_ovf));
            chk("udf",   int'(op_udf),   int'(m_udf));
        end
    end

    task automatic step(bit r, bit pu, bit po, bit cl, int w);
        Reset    = r;
        op_push  = pu;
        op_pop   = po;
        op_clear = cl;
        op_wdata = 4'(w);
        @(posedge Clock);
        model(r, pu, po, cl, w & 15);
        @(negedge Clock);
        chk_en = 1;
    endtask

    task automatic push(int w); step(1, 1, 0, 0, w); endtask
    task automatic pop();       step(1, 0, 1, 0, 0); endtask
    task automatic clr();       step(1, 0, 0, 1, 0); endtask

    initial begin
        Reset = 0; op_push = 0; op_pop = 0; op_clear = 0; op_wdata = 0;
        @(negedge Clock);

        // 1: reset then push 3,5,7
        step(0, 0, 0, 0, 0);
        chk("rst_data", int'(op_data), 0);
        chk("rst_empty", int'(op_empty), 1);
        chk("rst_flags", int'({op_ovf, op_udf, op_full}), 0);
        push(3); chk("p3", int'(op_data), 3);
        push(5); chk("p5", int'(op_data), 5);
        push(7); chk("p7", int'(op_data), 7);
        chk("p7_cnt", int'(op_count), 3);
        chk("p7_empty", int'(op_empty), 0);

        // 2: pop order and underflow
        pop(); chk("pop5", int'(op_data), 5);
        pop(); chk("pop3", int'(op_data), 3);
        pop(); chk("pop0", int'(op_data), 0);
        chk("pop_empty", int'(op_empty), 1);
        pop(); chk("udf", int'(op_udf), 1);
        chk("udf_cnt", int'(op_count), 0);

        // 3: fill to depth (values wrap to 4 bits), overflow, drain
        clr();
        for (int i = 1; i <= 16; i++) push(i);
        chk("fill_full", int'(op_full), 1);
        chk("fill_cnt", int'(op_count), 16);
        chk("fill_top", int'(op_data), 0);
        push(9);
        chk("ovf", int'(op_ovf), 1);
        chk("ovf_top", int'(op_data), 0);
        pop(); chk("drain15", int'(op_data), 15);
        for (int i = 0; i < 14; i++) pop();
        chk("drain_last", int'(op_data), 1);
        pop(); chk("drain0", int'(op_data), 0);

        // 4: simultaneous push+pop
        clr();
        push(2); push(4);
        step(1, 1, 1, 0, 6);
        chk("pp_top", int'(op_data), 6);
        chk("pp_cnt", int'(op_count), 2);
        pop(); chk("pp_pop", int'(op_data), 2);
        clr();
        step(1, 1, 1, 0, 9);
        chk("pp_e_top", int'(op_data), 9);
        chk("pp_e_cnt", int'(op_count), 1);
        chk("pp_e_udf", int'(op_udf), 0);

        // 5: clear beats push, clears ovf
        clr();
        for (int i = 1; i <= 16; i++) push(i);
        push(9);
        for (int i = 0; i < 13; i++) pop();
        chk("c_top", int'(op_data), 3);
        chk("c_ovf", int'(op_ovf), 1);
        step(1, 1, 0, 1, 8);
        chk("c_cnt", int'(op_count), 0);
        chk("c_data", int'(op_data), 0);
        chk("c_ovf0", int'(op_ovf), 0);
        push(8);
        chk("c_p8", int'(op_data), 8);
        chk("c_p8cnt", int'(op_count), 1);

        // 6: reset beats push
        push(1); push(2); push(3);
        chk("r_cnt4", int'(op_count), 4);
        step(0, 1, 0, 0, 5);
        chk("r_cnt", int'(op_count), 0);
        chk("r_data", int'(op_data), 0);

        // random traffic in phases biased to fill and drain
        for (int ph = 0; ph < 8; ph++) begin
            int bias = (ph % 2 == 0) ? 70 : 30;
            for (int c = 0; c < 250; c++) begin
                int rr = $urandom_range(0, 99);
                bit r  = ($urandom_range(0, 99) != 0);
                bit cl = (rr < 3);
                bit pu = ($urandom_range(0, 99) < bias);
                bit po = ($urandom_range(0, 99) < (100 - bias));
                step(r, pu, po, cl, $urandom_range(0, 15));
            end
        end

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
